// File: rtl/conv3x3_stream_core_pkg.sv
// Shared constants and helpers for the 3x3 streaming convolution core.
package conv3x3_stream_core_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned WGT_W     = 8;
    localparam int unsigned KERNEL    = 3;
    localparam int unsigned KTAPS     = KERNEL * KERNEL;
    localparam int unsigned ACC_W_DEF = 32;

    // Flat tap index for window/kernel position (row r, column c).
    function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
        return KERNEL * r + c;
    endfunction

endpackage

// File: rtl/conv3x3_stream_core_row_delay_line.sv
// One image row of delay: IMG_W-deep circular buffer of pixels.
// 'tap' is the sample written IMG_W enabled cycles ago (zero until written),
// read combinationally so that two instances can be chained with no extra lag.
module conv3x3_stream_core_row_delay_line
    import conv3x3_stream_core_pkg::*;
#(
    parameter int unsigned IMG_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] tap
);

    localparam int unsigned PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [PIX_W-1:0] mem_q [IMG_W];
    logic [PTR_W-1:0] ptr_q;

    // Oldest entry sits at the write pointer; it is overwritten on this edge.
    assign tap = mem_q[ptr_q];

    // Circular write with wrapping pointer; reset clears history to zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en) begin
            mem_q[ptr_q] <= din;
            ptr_q        <= (ptr_q == PTR_W'(IMG_W - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

endmodule

// File: rtl/conv3x3_stream_core.sv
// Streaming 3x3 convolution datapath: two chained line delays feed a 3x3
// window register array, followed by a signed multiply-accumulate register.
// in_valid is the single enable for every pipeline register.
module conv3x3_stream_core
    import conv3x3_stream_core_pkg::*;
#(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned PADDING = 1,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    input  logic [KTAPS*WGT_W-1:0]   weights,
    output logic [KTAPS*PIX_W-1:0]   win_taps,
    output logic signed [ACC_W-1:0]  out_mac
);

    // PADDING only exists for interface compatibility; reject illegal values.
    if (PADDING > 2) begin : g_padding_check
        $error("conv3x3_stream_core: PADDING must be 0..2");
    end

    logic [PIX_W-1:0]                  line1_tap, line2_tap;
    logic [PIX_W-1:0]                  row0_q, row1_q, row2_q;
    logic [KERNEL-1:0][PIX_W-1:0]      row_vec;
    logic [KTAPS-1:0][PIX_W-1:0]       win_q, win_d;
    logic signed [ACC_W-1:0]           px_ext [KTAPS];
    logic signed [ACC_W-1:0]           wt_ext [KTAPS];
    logic signed [ACC_W-1:0]           mac_q, mac_d;

    conv3x3_stream_core_row_delay_line #(
        .IMG_W (IMG_W)
    ) u_line1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (in_data),
        .tap   (line1_tap)
    );

    // Second line is fed by the first line's outgoing sample: 2*IMG_W total.
    conv3x3_stream_core_row_delay_line #(
        .IMG_W (IMG_W)
    ) u_line2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (line1_tap),
        .tap   (line2_tap)
    );

    // Line-buffer output registers: row2 newest line, row0 oldest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row0_q <= '0;
            row1_q <= '0;
            row2_q <= '0;
        end else if (in_valid) begin
            row2_q <= in_data;
            row1_q <= line1_tap;
            row0_q <= line2_tap;
        end
    end

    assign row_vec[0] = row0_q;
    assign row_vec[1] = row1_q;
    assign row_vec[2] = row2_q;

    // Window next state: shift each row left, newest sample enters column 2.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < KERNEL; r++) begin
            win_d[tap_idx(r, 0)] = win_q[tap_idx(r, 1)];
            win_d[tap_idx(r, 1)] = win_q[tap_idx(r, 2)];
            win_d[tap_idx(r, 2)] = row_vec[r];
        end
    end

    // Window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (in_valid) begin
            win_q <= win_d;
        end
    end

    // Sum of products: unsigned pixels times signed taps, full precision.
    always_comb begin
        mac_d = '0;
        for (int t = 0; t < KTAPS; t++) begin
            px_ext[t] = ACC_W'(win_q[t]);
            wt_ext[t] = ACC_W'($signed(weights[t*WGT_W +: WGT_W]));
            mac_d     = mac_d + px_ext[t] * wt_ext[t];
        end
    end

    // Registered MAC output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_q <= '0;
        end else if (in_valid) begin
            mac_q <= mac_d;
        end
    end

    assign win_taps = win_q;
    assign out_mac  = mac_q;

endmodule

// File: tb/tb_conv3x3_stream_core.sv
// Scoreboard bench for conv3x3_stream_core with IMG_W=4.
module tb_conv3x3_stream_core;

    localparam int W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = '0;
    logic [71:0]        wts = '0;
    logic [71:0]        win_taps;
    logic signed [31:0] out_mac;

    conv3x3_stream_core #(
        .IMG_W   (W),
        .PADDING (1),
        .ACC_W   (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .weights  (wts),
        .win_taps (win_taps),
        .out_mac  (out_mac)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          exp_mac;
        int          win_kind;  // 0 none, 1 full window, 2 right column only
        logic [71:0] exp_win;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hist [0:511];
    int   n = 0;

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int sample(input int idx);
        return (idx >= 1 && idx <= n) ? hist[idx] : 0;
    endfunction

    // Window after valid edge m: win(r,c) = sample m-3+c-(2-r)*W.
    function automatic logic [71:0] model_win(input int m);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[8*(3*r+c) +: 8] = 8'(sample(m - 3 + c - (2 - r) * W));
        return v;
    endfunction

    // out_mac after valid edge m uses the window after edge m-1.
    function automatic int model_mac(input int m);
        int               acc;
        logic signed [7:0] wv;
        acc = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                wv  = wts[8*(3*r+c) +: 8];
                acc = acc + sample(m - 4 + c - (2 - r) * W) * int'(wv);
            end
        return acc;
    endfunction

    // Issue one valid sample and queue its expected response.
    // hand_mac is used when use_hand=1; wk selects the window check.
    task automatic send(input logic [7:0] d, input bit use_hand, input int hand_mac,
                        input int wk, input logic [71:0] hand_win, input string nm);
        exp_t e;
        n++;
        hist[n]    = int'(d);
        e.exp_mac  = use_hand ? hand_mac : model_mac(n);
        e.win_kind = wk;
        e.exp_win  = (wk == 1) ? model_win(n) : hand_win;
        e.name     = nm;
        sb_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Idle cycles with outputs expected to hold at the model's current state.
    task automatic idle(input int k, input string nm);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            check_int({nm, "_mac_hold"}, int'(out_mac), model_mac(n));
            check_vec({nm, "_win_hold"}, win_taps, model_win(n));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_int("reset_mac", int'(out_mac), 0);
        check_vec("reset_win", win_taps, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n     = 0;
    endtask

    // Monitor: after every valid edge pop one expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (in_valid && rst_n) begin
                #1;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got output with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    check_int({e.name, "_mac"}, int'(out_mac), e.exp_mac);
                    if (e.win_kind == 1)
                        check_vec({e.name, "_win"}, win_taps, e.exp_win);
                    else if (e.win_kind == 2)
                        check_vec({e.name, "_col2"},
                                  {48'd0, win_taps[71:64], win_taps[47:40], win_taps[23:16]},
                                  {48'd0, e.exp_win[71:64], e.exp_win[47:40], e.exp_win[23:16]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [71:0] col;

        // Reset, then hold in_valid low: everything stays zero.
        #2;
        check_int("por_mac", int'(out_mac), 0);
        check_vec("por_win", win_taps, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10, "por");

        // Delay check: ramp 1..13, right column after edge 13 is (4,8,12).
        do_reset();
        wts = {9{8'h01}};
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0, 0, 1, '0, "ramp");
        col = '0;
        col[23:16] = 8'd4;
        col[47:40] = 8'd8;
        col[71:64] = 8'd12;
        send(8'd13, 1'b0, 0, 2, col, "ramp13");

        // Constant field of 10s.
        do_reset();
        wts = {9{8'h01}};
        for (int i = 1; i <= 14; i++) send(8'd10, 1'b0, 0, 0, '0, "const");
        send(8'd10, 1'b1, 90, 1, '0, "const_ones");
        wts = '0;
        wts[39:32] = 8'h02;
        send(8'd10, 1'b1, 20, 0, '0, "const_centre2");

        // Signed extremes.
        do_reset();
        wts = {9{8'hFF}};
        for (int i = 1; i <= 14; i++) send(8'd255, 1'b0, 0, 0, '0, "ext");
        send(8'd255, 1'b1, -2295, 0, '0, "ext_neg1");
        wts = {9{8'h7F}};
        send(8'd255, 1'b1, 291465, 0, '0, "ext_127");
        wts = '0;
        wts[39:32] = 8'h80;
        send(8'd255, 1'b1, -32640, 0, '0, "ext_m128");

        // Stalls inside a 3-row ramp with a mixed kernel.
        do_reset();
        wts = {8'h09, 8'hF8, 8'h07, 8'hFA, 8'h05, 8'hFC, 8'h03, 8'hFE, 8'h01};
        for (int i = 1; i <= 12; i++) begin
            send(8'(10 * i + 3), 1'b0, 0, 1, '0, "stall");
            if (i == 3) idle(1, "gap1");
            if (i == 8) idle(5, "gap5");
        end

        // Reset mid-frame: no 50 may survive into the new stream.
        do_reset();
        wts = {9{8'h01}};
        for (int i = 1; i <= 6; i++) send(8'd50, 1'b0, 0, 0, '0, "pre");
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'd7, 1'b0, 0, 1, '0, "post");
        send(8'd7, 1'b1, 42, 1, '0, "post9");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        check_int("sb_drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
